// File: rtl/dn_writer.sv
// -----------------------------------------------------------------------------
// dn_writer
//
// Parses a byte stream of download frames and turns the payload into a
// sequence of single-cycle memory write strobes.
//
// Frame layout:   INDEX, LEN_LO, LEN_HI, N payload bytes [, CHK]
//                 N = {LEN_HI, LEN_LO} + 1   (1 .. 65536)
//
// Optional feature (compile-time macro):
//   DN_WRITER_CHECKSUM_EN - a CHK byte follows the payload. It must equal the
//                           modulo-256 sum of the payload bytes. A mismatch
//                           raises err at frame end. Writes already issued
//                           stay issued.
//
// Parameters:
//   MAX_INDEX - highest accepted memory index. A frame with a larger index
//               is consumed without any writes and raises err at frame end.
//
// Ports:
//   clk_sys  in   system clock, rising edge
//   reset_n  in   asynchronous active-low reset
//   s_data   in   [7:0] incoming byte
//   s_valid  in   s_data valid
//   s_ready  out  byte accepted when s_valid && s_ready
//   abort    in   synchronous frame abort (also blocks byte acceptance)
//   dn_addr  out  [16:0] payload byte offset within the frame
//   dn_data  out  [7:0]  payload byte
//   dn_wr    out  single-cycle write strobe
//   dn_index out  [7:0]  memory index of the current frame
//   dn_busy  out  high from the accepted INDEX byte until frame end
//   done     out  one-cycle pulse at frame end
//   err      out  sticky error, cleared by the next accepted INDEX byte
// -----------------------------------------------------------------------------
module dn_writer #(
    parameter int MAX_INDEX = 3
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic        abort,
    output logic [16:0] dn_addr,
    output logic [7:0]  dn_data,
    output logic        dn_wr,
    output logic [7:0]  dn_index,
    output logic        dn_busy,
    output logic        done,
    output logic        err
);

`ifdef DN_WRITER_CHECKSUM_EN
    localparam logic CHK_EN_C = 1'b1;
`else
    localparam logic CHK_EN_C = 1'b0;
`endif

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LEN_LO = 3'd1;
    localparam logic [2:0] ST_LEN_HI = 3'd2;
    localparam logic [2:0] ST_DATA   = 3'd3;
    localparam logic [2:0] ST_CHK    = 3'd4;

    localparam logic [31:0] MAX_INDEX_C = 32'(MAX_INDEX);

    // Running modulo-256 payload checksum.
    function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
        logic [7:0] sum;
        sum = acc + b;
        return sum;
    endfunction

    logic [2:0]  state_r;
    logic [15:0] len_r;       // payload length minus one
    logic [16:0] cnt_r;       // offset of the next payload byte
    logic [7:0]  sum_r;
    logic        drop_r;      // current frame index is out of range

    logic [16:0] dn_addr_r;
    logic [7:0]  dn_data_r;
    logic        dn_wr_r;
    logic [7:0]  dn_index_r;
    logic        dn_busy_r;
    logic        done_r;
    logic        err_r;

    logic        accept_s;
    logic        last_pay_s;
    logic        idx_drop_s;

    // The block can take a byte every cycle; only reset and abort hold it off.
    assign s_ready    = reset_n & ~abort;
    assign accept_s   = s_valid & s_ready;
    // cnt_r is one bit wider than len_r so the 65536th byte (offset 0xFFFF)
    // compares without wrap.
    assign last_pay_s = (cnt_r == {1'b0, len_r});
    assign idx_drop_s = ({24'd0, s_data} > MAX_INDEX_C);

    assign dn_addr  = dn_addr_r;
    assign dn_data  = dn_data_r;
    assign dn_wr    = dn_wr_r;
    assign dn_index = dn_index_r;
    assign dn_busy  = dn_busy_r;
    assign done     = done_r;
    assign err      = err_r;

    // Frame parser state machine: one step per accepted byte.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else if (abort) begin
            state_r <= ST_IDLE;
        end else if (accept_s) begin
            case (state_r)
                ST_IDLE:   state_r <= ST_LEN_LO;
                ST_LEN_LO: state_r <= ST_LEN_HI;
                ST_LEN_HI: state_r <= ST_DATA;
                ST_DATA: begin
                    if (last_pay_s) begin
                        state_r <= CHK_EN_C ? ST_CHK : ST_IDLE;
                    end else begin
                        state_r <= ST_DATA;
                    end
                end
                ST_CHK:    state_r <= ST_IDLE;
                default:   state_r <= ST_IDLE;
            endcase
        end else if (state_r > ST_CHK) begin
            // Unused encoding: recover to a known state.
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_r;
        end
    end

    // Frame header fields, payload offset counter and checksum accumulator.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            len_r  <= 16'd0;
            cnt_r  <= 17'd0;
            sum_r  <= 8'd0;
            drop_r <= 1'b0;
        end else if (accept_s && !abort) begin
            case (state_r)
                ST_IDLE: begin
                    drop_r <= idx_drop_s;
                    cnt_r  <= 17'd0;
                    sum_r  <= 8'd0;
                end
                ST_LEN_LO: len_r[7:0]  <= s_data;
                ST_LEN_HI: len_r[15:8] <= s_data;
                ST_DATA: begin
                    cnt_r <= cnt_r + 17'd1;
                    sum_r <= csum_add(sum_r, s_data);
                end
                default: begin
                    len_r <= len_r;
                end
            endcase
        end else begin
            len_r <= len_r;
        end
    end

    // Registered write port, status and frame-end signalling.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            dn_addr_r  <= 17'd0;
            dn_data_r  <= 8'd0;
            dn_wr_r    <= 1'b0;
            dn_index_r <= 8'd0;
            dn_busy_r  <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            // Strobes default low every cycle; this also drops a write that
            // was about to issue when abort arrives.
            dn_wr_r <= 1'b0;
            done_r  <= 1'b0;
            if (abort) begin
                dn_busy_r <= 1'b0;
                if (state_r != ST_IDLE) begin
                    err_r <= 1'b1;
                end else begin
                    err_r <= err_r;
                end
            end else if (accept_s) begin
                case (state_r)
                    ST_IDLE: begin
                        dn_index_r <= s_data;
                        dn_addr_r  <= 17'd0;
                        dn_busy_r  <= 1'b1;
                        err_r      <= 1'b0;
                    end
                    ST_DATA: begin
                        if (!drop_r) begin
                            dn_wr_r   <= 1'b1;
                            dn_addr_r <= cnt_r;
                            dn_data_r <= s_data;
                        end else begin
                            dn_addr_r <= dn_addr_r;
                        end
                        if (last_pay_s && !CHK_EN_C) begin
                            done_r    <= 1'b1;
                            dn_busy_r <= 1'b0;
                            err_r     <= err_r | drop_r;
                        end else begin
                            dn_busy_r <= dn_busy_r;
                        end
                    end
                    ST_CHK: begin
                        done_r    <= 1'b1;
                        dn_busy_r <= 1'b0;
                        err_r     <= err_r | drop_r | (s_data != sum_r);
                    end
                    default: begin
                        dn_busy_r <= dn_busy_r;
                    end
                endcase
            end else begin
                dn_busy_r <= dn_busy_r;
            end
        end
    end

endmodule

// File: doc/dn_writer.md
DN_WRITER -- requirements
Module: dn_writer

Interface
REQ-001 SHALL have parameter MAX_INDEX, default 3: highest dn_index accepted; frames with larger index are consumed without writes.
REQ-002 SHALL have port clk_sys  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port s_data  input  8  incoming byte stream.
REQ-005 SHALL have port s_valid  input  1  s_data valid.
REQ-006 SHALL have port s_ready  output  1  byte accepted on a cycle where s_valid && s_ready.
REQ-007 SHALL have port abort  input  1  synchronous frame abort.
REQ-008 SHALL have port dn_addr  output  17  payload byte offset within frame.
REQ-009 SHALL have port dn_data  output  8  payload byte.
REQ-010 SHALL have port dn_wr  output  1  single-cycle write strobe.
REQ-011 SHALL have port dn_index  output  8  target memory index of current frame.
REQ-012 SHALL have port dn_busy  output  1  high from accepted index byte until frame end.
REQ-013 SHALL have port done  output  1  one-cycle pulse at frame end.
REQ-014 SHALL have port err  output  1  sticky error flag, cleared by next accepted index byte.

Function
REQ-015 SHALL parse frames: INDEX byte, LEN_LO, LEN_HI, then N payload bytes, where N = {LEN_HI,LEN_LO}+1 (1..65536).
REQ-016 SHALL use states IDLE -> LEN_LO -> LEN_HI -> DATA -> (CHK when enabled) -> IDLE, advancing one state per accepted byte, except DATA which exits after the Nth byte.
REQ-017 SHALL drive s_ready = 1 in every state when reset_n is high and abort is low; s_ready = 0 while abort is high.
REQ-018 SHALL, for each payload byte accepted in DATA, assert dn_wr for exactly the following cycle with dn_data = that byte and dn_addr = its 0-based offset (latency 1 cycle).
REQ-019 SHALL hold dn_addr and dn_data stable when dn_wr is low; dn_addr SHALL reset to 0 on each accepted INDEX byte.
REQ-020 SHALL compute dn_addr in 17 bits so offset 0xFFFF (N = 65536) is reached without wrap.
REQ-021 SHALL latch dn_index on the accepted INDEX byte and hold it until the next INDEX byte.
REQ-022 SHALL, when the latched index > MAX_INDEX, consume the payload with dn_wr held low and set err at frame end.
REQ-023 SHALL pulse done for one cycle on the cycle after the final frame byte (last payload, or checksum when enabled) is accepted, coincident with the final dn_wr; dn_busy SHALL fall on that same cycle.
REQ-024 SHALL, on abort high, return to IDLE next cycle, deassert dn_busy, suppress any pending dn_wr, set err if a frame was in progress, and not pulse done.
REQ-025 SHALL accept back-to-back bytes at one per cycle with no bubbles, including an INDEX byte on the cycle immediately after a frame's last byte.

Reset
REQ-026 SHALL, while reset_n is low, force state IDLE, s_ready=0, dn_addr=0, dn_data=0, dn_wr=0, dn_index=0, dn_busy=0, done=0, err=0.
REQ-027 SHALL discard any partially received frame when reset asserts mid-frame; no dn_wr SHALL occur for bytes of that frame after reset releases.

Configuration
REQ-028 SHALL provide macro DN_WRITER_CHECKSUM_EN.
REQ-029 SHALL, when DN_WRITER_CHECKSUM_EN is defined, expect one CHK byte after the payload, equal to the 8-bit modulo-256 sum of the payload bytes, and set err at frame end on mismatch (writes already issued are not undone).
REQ-030 SHALL, when DN_WRITER_CHECKSUM_EN is undefined, omit the CHK state, and treat the byte after the payload as the next frame's INDEX byte.

Verification
REQ-031 SHALL cover: frame 02,03,00,AA,BB,CC,DD (plus CHK 0E when enabled) -> dn_wr at offsets 0..3 with AA..DD, dn_index=2, one done pulse, err=0.
REQ-032 SHALL cover: index 05 with MAX_INDEX=3, LEN=0001, 2 payload bytes -> zero dn_wr pulses, err=1 at frame end, next frame with index 0 clears err.
REQ-033 SHALL cover: abort asserted after 2 of 4 payload bytes -> 2 dn_wr pulses only, dn_busy=0 next cycle, err=1, no done; subsequent valid frame writes from offset 0.
REQ-034 SHALL cover: LEN=FFFF, continuous s_valid -> 65536 consecutive dn_wr, last dn_addr=0x0FFFF, done one cycle after the last byte.
REQ-035 SHALL cover: reset_n pulsed low mid-payload -> all outputs 0 immediately, remaining bytes not written, next frame decoded correctly.
REQ-036 SHALL cover (CHECKSUM_EN): correct payload with CHK off by one -> all payload dn_wr issued, err=1, done pulsed.
